fetch_unit: RTL and testbench

Instruction fetch stage of the multi-cycle core. Owns the program counter, issues word reads to the synchronous-read instruction RAM, captures each returned word with its PC, and presents it to decode through a valid/ready handshake. Accepts a redirect (branch/jump target) from later stages, discarding any in-flight fetch.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM state encoding and datapath widths.
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    RESP  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // True when a byte address sits on a 32-bit word boundary.
  function automatic logic pc_is_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction RAM port, decode handshake and redirect.
// fetch_fault exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              redirect;
  logic [31:0]       redirect_target;
  logic [29:0]       ram_addr;
  logic              ram_re;
  logic [INST_W-1:0] ram_dout;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [31:0]       inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              fetch_fault;

  modport master (
    input  redirect, redirect_target, ram_dout, inst_ready,
    output ram_addr, ram_re, inst_valid, inst, inst_pc, fetch_fault
  );

  modport slave (
    output redirect, redirect_target, ram_dout, inst_ready,
    input  ram_addr, ram_re, inst_valid, inst, inst_pc, fetch_fault
  );
`else
  modport master (
    input  redirect, redirect_target, ram_dout, inst_ready,
    output ram_addr, ram_re, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_target, ram_dout, inst_ready,
    input  ram_addr, ram_re, inst_valid, inst, inst_pc
  );
`endif

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues RAM reads, holds the fetched word for decode.
// FETCH_MISALIGN_CHECK_EN adds a sticky FAULT state for misaligned redirect targets.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  fetch_unit_if.master bus
);

  fetch_state_t      state_q;
  logic [31:0]       pc_q;
  logic [INST_W-1:0] inst_q;
  logic [31:0]       inst_pc_q;
  logic              inst_valid_q;
  logic [31:0]       pc_seq_d;
  logic [31:0]       target_d;
  logic              target_bad_s;
  logic              ram_re_s;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              fault_q;
`endif

  // Redirect target conditioning and sequential PC increment (wraps modulo 2^32).
  always_comb begin
    pc_seq_d     = pc_q + 32'd4;
    target_d     = bus.redirect_target;
    target_bad_s = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    target_bad_s = !pc_is_aligned(bus.redirect_target);
`else
    target_d     = bus.redirect_target & 32'hFFFF_FFFC;
`endif
  end

  // RAM read enable: reset and redirect both suppress any read this cycle.
  always_comb begin
    ram_re_s = 1'b0;
    if (!resetn || bus.redirect) begin
      ram_re_s = 1'b0;
    end else begin
      case (state_q)
        ISSUE:   ram_re_s = 1'b1;
        HOLD:    ram_re_s = bus.inst_ready;
        default: ram_re_s = 1'b0;
      endcase
    end
  end

  // Fetch FSM together with PC and the decode-facing instruction register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ISSUE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else if (bus.redirect) begin
      // A handshake completing this cycle still clears valid; an in-flight response is dropped.
      pc_q         <= target_d;
      inst_valid_q <= 1'b0;
      state_q      <= target_bad_s ? FAULT : ISSUE;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q      <= target_bad_s;
`endif
    end else begin
      case (state_q)
        ISSUE: begin
          state_q <= RESP;
        end
        RESP: begin
          inst_q       <= bus.ram_dout;
          inst_pc_q    <= pc_q;
          inst_valid_q <= 1'b1;
          pc_q         <= pc_seq_d;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= RESP;
          end else begin
            state_q      <= HOLD;
          end
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= ISSUE;
        end
      endcase
    end
  end

  assign bus.ram_re     = ram_re_s;
  assign bus.ram_addr   = pc_q[31:2];
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations (FETCH_MISALIGN_CHECK_EN aware).
module tb_fetch_unit;

  logic clk;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // RAM contents as a pure function of word address; word 0 is the test-plan instruction.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    logic [31:0] w;
    if (a == 30'd0) w = 32'h0050_0093;
    else            w = ({2'b00, a} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    return w;
  endfunction

  always @(posedge clk) begin
    if (bus.ram_re) bus.ram_dout <= mem_word(bus.ram_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a fetch is owed, in flight, or the instruction is being held.
  logic        m_known = 1'b0;
  logic [31:0] m_pc    = 32'h0;
  logic        m_owed  = 1'b0;
  logic        m_pend  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_inst  = 32'h0;
  logic [31:0] m_ipc   = 32'h0;
  logic        m_fault = 1'b0;
  logic [31:0] acc_q[$];

  always @(negedge clk) begin
    logic exp_re;
    logic bad;
    exp_re = m_known && resetn && !bus.redirect && !m_fault &&
             (m_owed || (m_valid && bus.inst_ready));
    if (m_known) begin
      chk("ram_re", {31'd0, bus.ram_re}, {31'd0, exp_re});
      if (exp_re) chk("ram_addr", {2'b00, bus.ram_addr}, {2'b00, m_pc[31:2]});
      chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_valid});
      chk("inst", bus.inst, m_inst);
      chk("inst_pc", bus.inst_pc, m_ipc);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
`endif
      if (resetn && bus.inst_valid && bus.inst_ready) acc_q.push_back(bus.inst_pc);
    end
    if (!resetn) begin
      m_known = 1'b1; m_pc = 32'h0; m_owed = 1'b1; m_pend = 1'b0;
      m_valid = 1'b0; m_inst = 32'h0; m_ipc = 32'h0; m_fault = 1'b0;
    end else if (m_known) begin
      if (bus.redirect) begin
        m_valid = 1'b0;
        m_pend  = 1'b0;
        bad     = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        bad     = (bus.redirect_target[1:0] != 2'b00);
`endif
        m_fault = bad;
        m_owed  = !bad;
        m_pc    = bad ? bus.redirect_target : (bus.redirect_target & 32'hFFFF_FFFC);
      end else if (m_pend) begin
        m_valid = 1'b1;
        m_inst  = mem_word(m_pc[31:2]);
        m_ipc   = m_pc;
        m_pc    = m_pc + 32'd4;
        m_pend  = 1'b0;
      end else if (exp_re) begin
        m_pend = 1'b1;
        m_owed = 1'b0;
        if (m_valid && bus.inst_ready) m_valid = 1'b0;
      end
    end
  end

  task automatic drive(input logic rn, input logic rd, input logic [31:0] tgt, input logic rdy);
    resetn              = rn;
    bus.redirect        = rd;
    bus.redirect_target = tgt;
    bus.inst_ready      = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_acc [7];

  initial begin
    exp_acc = '{32'h0, 32'h4, 32'h40, 32'h100, 32'h104, 32'hFFFF_FFFC, 32'h0};
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick(); tick();
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_ram_re", {31'd0, bus.ram_re}, 32'd0);

    // First fetch after reset release, decode stalled.
    drive(1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("first_re", {31'd0, bus.ram_re}, 32'd1);
    chk("first_addr", {2'b00, bus.ram_addr}, 32'd0);
    tick();
    chk("resp_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("w0_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("w0_inst", bus.inst, 32'h0050_0093);
    chk("w0_pc", bus.inst_pc, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_inst", bus.inst, 32'h0050_0093);
    chk("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b1); #1;
    chk("release_re", {31'd0, bus.ram_re}, 32'd1);
    chk("release_addr", {2'b00, bus.ram_addr}, 32'd1);
    tick(); tick();
    chk("w1_pc", bus.inst_pc, 32'h4);

    // Redirect coincident with acceptance of PC 4.
    drive(1'b1, 1'b1, 32'h40, 1'b1); #1;
    chk("redir_hs_re", {31'd0, bus.ram_re}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick(); tick();
    chk("tgt40_pc", bus.inst_pc, 32'h40);

    // Redirect during RESP of PC 8: word 8 is dropped.
    drive(1'b1, 1'b1, 32'h8, 1'b1); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b1, 1'b1, 32'h100, 1'b1); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1); tick(); tick();
    chk("tgt100_pc", bus.inst_pc, 32'h100);
    tick(); tick();
    chk("seq104_pc", bus.inst_pc, 32'h104);

    // Wrap at the top of the address space.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1); tick(); tick();
    chk("top_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", {2'b00, bus.ram_addr}, 32'd0);
    tick(); tick();
    chk("wrap_pc", bus.inst_pc, 32'h0);
    chk("wrap_inst", bus.inst, 32'h0050_0093);
    drive(1'b1, 1'b0, 32'h0, 1'b0);

    // Reset while a response is in flight.
    drive(1'b1, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
    chk("midrst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("midrst_inst", bus.inst, 32'h0);
    chk("midrst_re", {31'd0, bus.ram_re}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0); tick(); tick();
    chk("post_rst_pc", bus.inst_pc, 32'h0);
    chk("post_rst_valid", {31'd0, bus.inst_valid}, 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
    drive(1'b1, 1'b1, 32'h102, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1); tick(); tick(); tick();
    chk("fault_sticky", {31'd0, bus.fetch_fault}, 32'd1);
    chk("fault_re", {31'd0, bus.ram_re}, 32'd0);
    drive(1'b1, 1'b1, 32'h200, 1'b1); tick();
    chk("fault_clear", {31'd0, bus.fetch_fault}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1); tick(); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("resume_pc", bus.inst_pc, 32'h200);
`else
    drive(1'b1, 1'b1, 32'h102, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0); tick(); tick();
    chk("mask_pc", bus.inst_pc, 32'h100);
`endif
    tick();

    chk("acc_count", acc_q.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < acc_q.size()) chk("acc_pc", acc_q[i], exp_acc[i]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
